switch_scanner: RTL and testbench

Strobed, debounced reader for the board's external switch wired between the `sda` (high-side drive) and `scl` (sense) pins. Instead of holding the high side permanently on and using the raw sense line directly, this block energises the switch briefly once per scan period. It waits for the line to settle, samples it through a synchroniser, and debounces the result. It provides a clean level plus one-cycle press and release events for downstream logic such as LED control, mode selection or reset requests.

---
 rtl/switch_scanner.sv | 169 ++++++++++++++++
 tb/tb_switch_scanner.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_scanner.sv
// switch_scanner
// Strobed, debounced reader for an external switch wired between a high-side
// drive pin (sda) and a sense pin (scl). Once per scan period the switch is
// energised, the sense line is allowed to settle, one synchronised sample is
// captured and fed to a debouncer that reports a clean level plus one-cycle
// press/release events.
//
// Ports:
//   clk48        in   system clock (48 MHz nominal)
//   rst_n        in   asynchronous active-low reset
//   scl          in   raw switch sense, asynchronous to clk48
//   sda          out  switch high-side drive, 1 = energised
//   sw_level     out  debounced switch state, 1 = closed
//   sw_press     out  one-cycle pulse on debounced 0->1
//   sw_release   out  one-cycle pulse on debounced 1->0
//   sample_valid out  one-cycle pulse per completed scan sample
module switch_scanner #(
  parameter int unsigned SCAN_PERIOD    = 48000,
  parameter int unsigned SETTLE_CYCLES  = 48,
  parameter int unsigned DEBOUNCE_COUNT = 8
) (
  input  logic clk48,
  input  logic rst_n,
  input  logic scl,
  output logic sda,
  output logic sw_level,
  output logic sw_press,
  output logic sw_release,
  output logic sample_valid
);

  localparam int unsigned PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_COUNT + 1);

  localparam logic [PW-1:0] PERIOD_LAST = PW'(SCAN_PERIOD - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE
  } state_t;

  // Sense synchroniser
  logic scl_meta_q, scl_s_q;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_q <= 1'b0;
      scl_s_q    <= 1'b0;
    end else begin
      scl_meta_q <= scl;
      scl_s_q    <= scl_meta_q;
    end
  end

  // Free-running scan period counter
  logic [PW-1:0] period_q, period_d;

  always_comb begin
    period_d = period_q + PW'(1);
    if (period_q == PERIOD_LAST) begin
      period_d = '0;
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
    end else begin
      period_q <= period_d;
    end
  end

  // Scan FSM
  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          capture;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        settle_d = '0;
        if (period_q == PERIOD_LAST) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      SAMPLE: begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        settle_d = '0;
      end
    endcase
  end

  // Debouncer, evaluated only on a capture
  logic          level_q, level_d;
  logic [DW-1:0] agree_q, agree_d;
  logic          press_d, release_d;

  always_comb begin
    level_d   = level_q;
    agree_d   = agree_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (capture) begin
      if (scl_s_q == level_q) begin
        agree_d = '0;
      end else if (agree_q == DEB_LAST) begin
        // This sample is the DEBOUNCE_COUNT-th consecutive disagreement.
        level_d   = ~level_q;
        agree_d   = '0;
        press_d   = ~level_q;
        release_d = level_q;
      end else begin
        agree_d = agree_q + DW'(1);
      end
    end
  end

  logic sda_q, press_q, release_q, valid_q;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      settle_q  <= '0;
      sda_q     <= 1'b0;
      level_q   <= 1'b0;
      agree_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      // Registered decode of the current state: the drive window trails the
      // FSM by one cycle and therefore still covers the capture edge.
      sda_q     <= (state_q != IDLE);
      level_q   <= level_d;
      agree_q   <= agree_d;
      press_q   <= press_d;
      release_q <= release_d;
      valid_q   <= capture;
    end
  end

  assign sda          = sda_q;
  assign sw_level     = level_q;
  assign sw_press     = press_q;
  assign sw_release   = release_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_switch_scanner.sv
module tb_switch_scanner;

  localparam int unsigned P = 16;
  localparam int unsigned S = 4;
  localparam int unsigned D = 3;

  logic clk48 = 1'b0;
  logic rst_n = 1'b0;
  logic scl   = 1'b0;
  logic sda, sw_level, sw_press, sw_release, sample_valid;

  always #5 clk48 = ~clk48;

  switch_scanner #(
    .SCAN_PERIOD   (P),
    .SETTLE_CYCLES (S),
    .DEBOUNCE_COUNT(D)
  ) dut (
    .clk48       (clk48),
    .rst_n       (rst_n),
    .scl         (scl),
    .sda         (sda),
    .sw_level    (sw_level),
    .sw_press    (sw_press),
    .sw_release  (sw_release),
    .sample_valid(sample_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of per-scan expected outcomes
  typedef struct {
    logic level;
    logic press;
    logic rel;
  } exp_t;

  exp_t expq[$];
  logic m_level = 1'b0;
  int   m_run   = 0;

  task automatic model_step(input logic s);
    exp_t e;
    e.press = 1'b0;
    e.rel   = 1'b0;
    if (s == m_level) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == D) begin
        m_level = ~m_level;
        m_run   = 0;
        e.press = m_level;
        e.rel   = ~m_level;
      end
    end
    e.level = m_level;
    expq.push_back(e);
  endtask

  // Scoreboard monitor
  logic sb_level = 1'b0;

  always @(negedge clk48) begin
    exp_t e;
    if (!rst_n) begin
      sb_level = 1'b0;
    end else if (sample_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got sample_valid=1 expected no sample at %0t", $time);
      end else begin
        e = expq.pop_front();
        check("sample_level", sw_level, e.level);
        check("sample_press", sw_press, e.press);
        check("sample_release", sw_release, e.rel);
        sb_level = e.level;
      end
    end else begin
      check("level_hold", sw_level, sb_level);
      check("press_idle", sw_press, 0);
      check("release_idle", sw_release, 0);
    end
  end

  // Drive-window timing monitor
  int edges;
  always @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  logic prev_sda  = 1'b0;
  int   last_rise = -1;
  int   hi_len    = 0;

  always @(negedge clk48) begin
    if (!rst_n) begin
      prev_sda  = 1'b0;
      last_rise = -1;
      hi_len    = 0;
    end else begin
      if (sda && !prev_sda) begin
        if (last_rise < 0) check("first_rise_edge", edges, P + 1);
        else               check("rise_interval", edges - last_rise, P);
        last_rise = edges;
        hi_len    = 1;
      end else if (sda) begin
        hi_len++;
      end else if (prev_sda) begin
        check("sda_high_len", hi_len, S + 1);
      end
      prev_sda = sda;
    end
  end

  task automatic wait_rise(input bit noise);
    int n = 0;
    forever begin
      @(negedge clk48);
      if (sda === 1'b1) break;
      if (noise) scl = 1'($urandom_range(0, 1));
      n++;
      if (n > 3 * P) begin
        checks++;
        errors++;
        $display("FAIL sda_rise_timeout: got no rise expected rise within %0d cycles", 3 * P);
        break;
      end
    end
  endtask

  // One scan: optional noise while idle, then present v for the whole drive window
  task automatic do_scan(input logic v, input bit noise);
    int n = 0;
    wait_rise(noise);
    scl = v;
    model_step(v);
    forever begin
      @(negedge clk48);
      if (sda === 1'b0) break;
      n++;
      if (n > 2 * S + 4) begin
        checks++;
        errors++;
        $display("FAIL sda_fall_timeout: got sda stuck high expected fall within %0d cycles", 2 * S + 4);
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sda"}, sda, 0);
    check({tag, "_level"}, sw_level, 0);
    check({tag, "_press"}, sw_press, 0);
    check({tag, "_release"}, sw_release, 0);
    check({tag, "_valid"}, sample_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] pat;
    logic v;

    repeat (3) @(negedge clk48);
    check_reset_outputs("por");
    #1 rst_n = 1'b1;

    // Idle switch
    repeat (3) do_scan(1'b0, 1'b0);
    // Press
    repeat (4) do_scan(1'b1, 1'b0);
    // Release
    repeat (4) do_scan(1'b0, 1'b0);
    // 1,0,1,1,0,1 never builds a run of 3
    pat = 6'b101101;
    for (int i = 5; i >= 0; i--) do_scan(pat[i], 1'b0);
    // Activity only while sda is low
    repeat (4) do_scan(1'b0, 1'b1);
    // Randomised runs with random idle-phase noise
    v = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) v = ~v;
      do_scan(v, 1'($urandom_range(0, 1)));
    end
    // Drive level high ahead of the reset test
    repeat (4) do_scan(1'b1, 1'b0);

    // Reset during the second DRIVE cycle (first cycle with sda high)
    wait_rise(1'b0);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    expq.delete();
    m_level = 1'b0;
    m_run   = 0;
    @(negedge clk48);
    check_reset_outputs("held_rst");
    #1 rst_n = 1'b1;
    scl = 1'b0;
    repeat (2) do_scan(1'b0, 1'b0);

    repeat (3) @(negedge clk48);
    check("queue_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
